// File: rtl/mem_refill_arbiter.sv
// Memory-port arbiter for I-cache refills and D-cache refills/writebacks.
// One line burst at a time; round-robin on ties, beats forwarded combinationally.
module mem_refill_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int LINE_WORDS = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  ic_req_valid,
    input  logic [ADDR_WIDTH-1:0] ic_req_addr,
    output logic                  ic_req_ready,
    output logic                  ic_rsp_valid,
    output logic [DATA_WIDTH-1:0] ic_rsp_data,
    output logic                  ic_rsp_last,
    input  logic                  dc_req_valid,
    input  logic                  dc_req_write,
    input  logic [ADDR_WIDTH-1:0] dc_req_addr,
    output logic                  dc_req_ready,
    input  logic                  dc_wdata_valid,
    input  logic [DATA_WIDTH-1:0] dc_wdata,
    output logic                  dc_wdata_ready,
    output logic                  dc_rsp_valid,
    output logic [DATA_WIDTH-1:0] dc_rsp_data,
    output logic                  dc_rsp_last,
    output logic                  mem_req_valid,
    output logic                  mem_req_write,
    output logic [ADDR_WIDTH-1:0] mem_req_addr,
    input  logic                  mem_req_ready,
    output logic                  mem_wdata_valid,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic                  mem_wdata_ready,
    input  logic                  mem_rdata_valid,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  busy
);
    localparam int CNT_W = $clog2(LINE_WORDS);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(LINE_WORDS - 1);
    localparam logic OWN_I = 1'b0;
    localparam logic OWN_D = 1'b1;

    typedef enum logic [1:0] {ST_IDLE, ST_ADDR, ST_READ, ST_WRITE} state_t;

    state_t                r_state;
    state_t                w_next_state;
    logic                  r_owner;
    logic                  r_is_write;
    logic                  r_rr_last;
    logic [ADDR_WIDTH-1:0] r_addr_q;
    logic [CNT_W-1:0]      r_beat_cnt;

    logic w_any_req;
    logic w_grant_d;
    logic w_rd_beat;
    logic w_wr_beat;
    logic w_last_beat;

    // On a tie the requester that did not win last time gets the port.
    assign w_any_req   = ic_req_valid | dc_req_valid;
    assign w_grant_d   = dc_req_valid & (~ic_req_valid | (r_rr_last == OWN_I));
    assign w_rd_beat   = (r_state == ST_READ) & mem_rdata_valid;
    assign w_wr_beat   = (r_state == ST_WRITE) & dc_wdata_valid & mem_wdata_ready;
    assign w_last_beat = (r_beat_cnt == LAST_BEAT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_owner    <= OWN_I;
            r_is_write <= 1'b0;
            r_rr_last  <= OWN_I;
            r_addr_q   <= '0;
            r_beat_cnt <= '0;
        end else begin
            if ((r_state == ST_IDLE) && w_any_req) begin
                r_owner    <= w_grant_d;
                r_is_write <= w_grant_d & dc_req_write;
                r_addr_q   <= w_grant_d ? dc_req_addr : ic_req_addr;
                r_rr_last  <= w_grant_d;
            end
            if ((r_state == ST_ADDR) && mem_req_ready) begin
                r_beat_cnt <= '0;
            end else if (w_rd_beat || w_wr_beat) begin
                r_beat_cnt <= r_beat_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE:  if (w_any_req) w_next_state = ST_ADDR;
            ST_ADDR:  if (mem_req_ready) w_next_state = r_is_write ? ST_WRITE : ST_READ;
            ST_READ:  if (w_rd_beat && w_last_beat) w_next_state = ST_IDLE;
            ST_WRITE: if (w_wr_beat && w_last_beat) w_next_state = ST_IDLE;
            default:  w_next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        ic_req_ready    = 1'b0;
        ic_rsp_valid    = 1'b0;
        ic_rsp_data     = '0;
        ic_rsp_last     = 1'b0;
        dc_req_ready    = 1'b0;
        dc_wdata_ready  = 1'b0;
        dc_rsp_valid    = 1'b0;
        dc_rsp_data     = '0;
        dc_rsp_last     = 1'b0;
        mem_req_valid   = 1'b0;
        mem_req_write   = 1'b0;
        mem_req_addr    = '0;
        mem_wdata_valid = 1'b0;
        mem_wdata       = '0;
        busy            = (r_state != ST_IDLE);
        case (r_state)
            ST_ADDR: begin
                mem_req_valid = 1'b1;
                mem_req_write = r_is_write;
                mem_req_addr  = r_addr_q;
                ic_req_ready  = mem_req_ready & (r_owner == OWN_I);
                dc_req_ready  = mem_req_ready & (r_owner == OWN_D);
            end
            ST_READ: begin
                if (r_owner == OWN_D) begin
                    dc_rsp_valid = w_rd_beat;
                    dc_rsp_data  = w_rd_beat ? mem_rdata : '0;
                    dc_rsp_last  = w_rd_beat & w_last_beat;
                end else begin
                    ic_rsp_valid = w_rd_beat;
                    ic_rsp_data  = w_rd_beat ? mem_rdata : '0;
                    ic_rsp_last  = w_rd_beat & w_last_beat;
                end
            end
            ST_WRITE: begin
                mem_wdata_valid = dc_wdata_valid;
                mem_wdata       = dc_wdata;
                dc_wdata_ready  = mem_wdata_ready;
                dc_rsp_last     = w_wr_beat & w_last_beat;
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_mem_refill_arbiter.sv
// Randomized bench for mem_refill_arbiter: caches and memory are driven at random and
// every cycle is compared against a transaction-level model of the arbitration rules.
module tb_mem_refill_arbiter;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int LW = 4;
    localparam logic [AW-1:0] LINE_MASK = ~AW'(LW * (DW / 8) - 1);

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          ic_req_valid, ic_req_ready, ic_rsp_valid, ic_rsp_last;
    logic [AW-1:0] ic_req_addr;
    logic [DW-1:0] ic_rsp_data;
    logic          dc_req_valid, dc_req_write, dc_req_ready;
    logic [AW-1:0] dc_req_addr;
    logic          dc_wdata_valid, dc_wdata_ready, dc_rsp_valid, dc_rsp_last;
    logic [DW-1:0] dc_wdata, dc_rsp_data;
    logic          mem_req_valid, mem_req_write, mem_req_ready;
    logic [AW-1:0] mem_req_addr;
    logic          mem_wdata_valid, mem_wdata_ready, mem_rdata_valid;
    logic [DW-1:0] mem_wdata, mem_rdata;
    logic          busy;

    always #5 clk = ~clk;

    mem_refill_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LINE_WORDS(LW)) dut (
        .clk(clk), .rst_n(rst_n),
        .ic_req_valid(ic_req_valid), .ic_req_addr(ic_req_addr), .ic_req_ready(ic_req_ready),
        .ic_rsp_valid(ic_rsp_valid), .ic_rsp_data(ic_rsp_data), .ic_rsp_last(ic_rsp_last),
        .dc_req_valid(dc_req_valid), .dc_req_write(dc_req_write), .dc_req_addr(dc_req_addr),
        .dc_req_ready(dc_req_ready), .dc_wdata_valid(dc_wdata_valid), .dc_wdata(dc_wdata),
        .dc_wdata_ready(dc_wdata_ready), .dc_rsp_valid(dc_rsp_valid), .dc_rsp_data(dc_rsp_data),
        .dc_rsp_last(dc_rsp_last), .mem_req_valid(mem_req_valid), .mem_req_write(mem_req_write),
        .mem_req_addr(mem_req_addr), .mem_req_ready(mem_req_ready),
        .mem_wdata_valid(mem_wdata_valid), .mem_wdata(mem_wdata), .mem_wdata_ready(mem_wdata_ready),
        .mem_rdata_valid(mem_rdata_valid), .mem_rdata(mem_rdata), .busy(busy)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Transaction-level model: phase 0 = no burst, 1 = address offered, 2 = beats flowing.
    int            m_phase = 0;
    bit            m_own_d = 1'b0;
    bit            m_write = 1'b0;
    bit            m_rr_d  = 1'b0;
    logic [AW-1:0] m_addr  = '0;
    int            m_beats = 0;
    logic [DW-1:0] wq[$];

    bit            ic_out = 1'b0, dc_out = 1'b0;
    bit            ic_rdy_seen = 1'b0, dc_rdy_seen = 1'b0;
    logic [AW-1:0] dc_wb_addr = '0;
    int            dc_wb_beat = 0;
    int            mode = 0;
    int            ic_bursts = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] wpat(input logic [AW-1:0] a, input int b);
        return a ^ (32'h5A00_0000 | 32'(b));
    endfunction

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"}, busy, 1'b0);
        check({tag, "_mem_req_valid"}, mem_req_valid, 1'b0);
        check({tag, "_mem_req_addr"}, mem_req_addr, '0);
        check({tag, "_ic_req_ready"}, ic_req_ready, 1'b0);
        check({tag, "_dc_req_ready"}, dc_req_ready, 1'b0);
        check({tag, "_ic_rsp_valid"}, ic_rsp_valid, 1'b0);
        check({tag, "_ic_rsp_last"}, ic_rsp_last, 1'b0);
        check({tag, "_dc_rsp_valid"}, dc_rsp_valid, 1'b0);
        check({tag, "_dc_rsp_last"}, dc_rsp_last, 1'b0);
        check({tag, "_mem_wdata_valid"}, mem_wdata_valid, 1'b0);
        check({tag, "_dc_wdata_ready"}, dc_wdata_ready, 1'b0);
        check({tag, "_ic_rsp_data"}, ic_rsp_data, '0);
    endtask

    task automatic drive();
        if (ic_rdy_seen) ic_req_valid = 1'b0;
        if (dc_rdy_seen) dc_req_valid = 1'b0;
        ic_rdy_seen = 1'b0;
        dc_rdy_seen = 1'b0;
        if (!ic_req_valid && !ic_out && $urandom_range(0, 3) == 0) begin
            ic_req_valid = 1'b1;
            ic_req_addr  = $urandom() & LINE_MASK;
        end
        if (mode == 0 && !dc_req_valid && !dc_out && $urandom_range(0, 3) == 0) begin
            dc_req_valid = 1'b1;
            dc_req_write = 1'($urandom_range(0, 1));
            dc_req_addr  = $urandom() & LINE_MASK;
            dc_wb_addr   = dc_req_addr;
            dc_wb_beat   = 0;
        end
        dc_wdata_valid = ($urandom_range(0, 3) != 0);
        dc_wdata       = wpat(dc_wb_addr, dc_wb_beat);
        if (mode == 1) begin
            mem_req_ready   = 1'b1;
            mem_wdata_ready = 1'b1;
            mem_rdata_valid = 1'b1;
        end else begin
            mem_req_ready   = ($urandom_range(0, 2) == 0);
            mem_wdata_ready = 1'($urandom_range(0, 1));
            mem_rdata_valid = ($urandom_range(0, 2) != 0);
        end
        mem_rdata = $urandom();
    endtask

    task automatic check_step();
        bit e_addr, e_rd, e_wr, rd_beat, wr_beat, last;
        e_addr  = (m_phase == 1);
        e_rd    = (m_phase == 2) && !m_write;
        e_wr    = (m_phase == 2) && m_write;
        rd_beat = e_rd && mem_rdata_valid;
        wr_beat = e_wr && dc_wdata_valid && mem_wdata_ready;
        last    = (m_beats == LW - 1);

        check("busy", busy, m_phase != 0);
        check("mem_req_valid", mem_req_valid, e_addr);
        if (e_addr) begin
            check("mem_req_addr", mem_req_addr, m_addr);
            check("mem_req_write", mem_req_write, m_write);
        end
        check("ic_req_ready", ic_req_ready, e_addr && !m_own_d && mem_req_ready);
        check("dc_req_ready", dc_req_ready, e_addr && m_own_d && mem_req_ready);
        check("ic_rsp_valid", ic_rsp_valid, rd_beat && !m_own_d);
        check("dc_rsp_valid", dc_rsp_valid, rd_beat && m_own_d);
        check("ic_rsp_last", ic_rsp_last, rd_beat && !m_own_d && last);
        check("dc_rsp_last", dc_rsp_last, ((rd_beat && m_own_d) || wr_beat) && last);
        if (rd_beat && !m_own_d) check("ic_rsp_data", ic_rsp_data, mem_rdata);
        if (rd_beat && m_own_d)  check("dc_rsp_data", dc_rsp_data, mem_rdata);
        check("mem_wdata_valid", mem_wdata_valid, e_wr && dc_wdata_valid);
        check("dc_wdata_ready", dc_wdata_ready, e_wr && mem_wdata_ready);
        if (e_wr && dc_wdata_valid) check("mem_wdata", mem_wdata, dc_wdata);

        // Memory side collects written beats; the whole line is compared at burst end.
        if (mem_wdata_valid && mem_wdata_ready) wq.push_back(mem_wdata);
        if (wr_beat && last) begin
            check("wb_beat_count", wq.size(), LW);
            for (int i = 0; i < wq.size() && i < LW; i++) check("wb_data", wq[i], wpat(m_addr, i));
            wq.delete();
        end

        if (ic_req_ready) begin ic_rdy_seen = 1'b1; ic_out = 1'b1; end
        if (dc_req_ready) begin dc_rdy_seen = 1'b1; dc_out = 1'b1; end
        if (ic_rsp_last) begin ic_out = 1'b0; ic_bursts++; end
        if (dc_rsp_last) dc_out = 1'b0;
        if (dc_wdata_valid && dc_wdata_ready) dc_wb_beat++;

        case (m_phase)
            0: if (ic_req_valid || dc_req_valid) begin
                m_own_d = dc_req_valid && (!ic_req_valid || !m_rr_d);
                m_write = m_own_d && dc_req_write;
                m_addr  = m_own_d ? dc_req_addr : ic_req_addr;
                m_rr_d  = m_own_d;
                m_phase = 1;
            end
            1: if (mem_req_ready) begin
                m_phase = 2;
                m_beats = 0;
            end
            default: if (rd_beat || wr_beat) begin
                if (last) m_phase = 0;
                else m_beats++;
            end
        endcase
    endtask

    task automatic run_cycles(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk); #1;
            drive();
            #4;
            check_step();
        end
    endtask

    initial begin
        bit found;
        int bursts_before;
        ic_req_valid = 0; ic_req_addr = '0; dc_req_valid = 0; dc_req_write = 0; dc_req_addr = '0;
        dc_wdata_valid = 0; dc_wdata = '0; mem_req_ready = 0; mem_wdata_ready = 0;
        mem_rdata_valid = 1; mem_rdata = 32'hDEAD_BEEF;

        #12;
        check_all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Tie right after reset: D must win first.
        @(posedge clk); #1;
        drive();
        ic_req_valid = 1'b1; ic_req_addr = 32'h100;
        dc_req_valid = 1'b1; dc_req_write = 1'b0; dc_req_addr = 32'h200;
        #4;
        check_step();

        run_cycles(1500);

        // Reach the third beat of an I-cache read, then reset mid-burst.
        mode = 1;
        found = 1'b0;
        for (int k = 0; k < 200 && !found; k++) begin
            @(posedge clk); #1;
            if (m_phase == 2 && m_beats == 2 && !m_own_d) begin
                found = 1'b1;
            end else begin
                drive();
                #4;
                check_step();
            end
        end
        check("mid_burst_reached", found, 1'b1);
        rst_n = 1'b0;
        ic_req_valid = 1'b0; dc_req_valid = 1'b0; mem_rdata_valid = 1'b1;
        #1;
        check_all_zero("mid_reset");
        m_phase = 0; m_rr_d = 1'b0; wq.delete();
        ic_out = 1'b0; dc_out = 1'b0; ic_rdy_seen = 1'b0; dc_rdy_seen = 1'b0;
        @(negedge clk);
        check_all_zero("mid_reset_hold");
        rst_n = 1'b1;
        bursts_before = ic_bursts;
        run_cycles(40);
        check("post_reset_ic_burst", ic_bursts > bursts_before, 1'b1);

        mode = 0;
        run_cycles(1500);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
